tensor_hgmma_scheduler: RTL and testbench

- Per-warp scheduler in front of the decoupled tensor core.
- Accepts HGMMA and HGMMA_WAIT uops from all warps and shares the single tensor-core initiate port between warps with round-robin arbitration.
- Limits outstanding HGMMAs per warp and tracks completions from writeback-last.
- Releases each warp's HGMMA_WAIT to commit only after that warp's outstanding HGMMAs have all completed.

---
 rtl/tensor_hgmma_scheduler.sv | 169 ++++++++++++++++
 tb/tb_tensor_hgmma_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_hgmma_scheduler.sv
// Per-warp HGMMA / HGMMA_WAIT scheduler in front of the decoupled tensor core.
// One uop slot per warp, round-robin kickoff and wait release, per-warp outstanding counters.
module tensor_hgmma_scheduler #(
    parameter int NUM_WARPS       = 4,
    parameter int NW_WIDTH        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_WIDTH-1:0]  req_wid,
    input  logic                 req_is_wait,
    output logic                 initiate_valid,
    output logic [NW_WIDTH-1:0]  initiate_wid,
    input  logic                 initiate_ready,
    input  logic                 done_valid,
    input  logic [NW_WIDTH-1:0]  done_wid,
    output logic                 wait_valid,
    output logic [NW_WIDTH-1:0]  wait_wid,
    input  logic                 wait_ready,
    output logic [NUM_WARPS-1:0] busy,
    output logic                 err_underflow
);

    if (MAX_OUTSTANDING >= (1 << CNT_W) || MAX_OUTSTANDING == 0) begin : g_bad_cfg
        $error("tensor_hgmma_scheduler: MAX_OUTSTANDING must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_WARPS-1:0] slot_valid;
    logic [NUM_WARPS-1:0] slot_wait;
    logic [CNT_W-1:0]     outstanding [NUM_WARPS];
    logic [NW_WIDTH-1:0]  ia_ptr;
    logic [NW_WIDTH-1:0]  wt_ptr;

    logic [NUM_WARPS-1:0] hg_elig;
    logic [NUM_WARPS-1:0] wt_elig;
    logic [NUM_WARPS-1:0] cnt_inc;
    logic [NUM_WARPS-1:0] cnt_dec;
    logic [NUM_WARPS-1:0] cnt_zero;
    logic                 ia_any;
    logic                 wt_any;
    logic [NW_WIDTH-1:0]  ia_win;
    logic [NW_WIDTH-1:0]  wt_win;
    logic                 ia_load;
    logic                 wt_load;
    logic                 req_fire;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [NW_WIDTH:0] rr_pick(input logic [NUM_WARPS-1:0] elig,
                                                  input logic [NW_WIDTH-1:0]  ptr);
        logic                found;
        logic [NW_WIDTH-1:0] idx;
        logic [NW_WIDTH-1:0] cand;
        int                  sum;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_WARPS) sum = sum - NUM_WARPS;
            cand = NW_WIDTH'(sum);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [NW_WIDTH-1:0] next_ptr(input logic [NW_WIDTH-1:0] win);
        if (win == NW_WIDTH'(NUM_WARPS - 1)) return '0;
        return win + NW_WIDTH'(1);
    endfunction

    assign req_ready = !slot_valid[req_wid];
    assign req_fire  = req_valid && req_ready;

    // The wait guard uses the pre-decrement count, so release trails the last done by a cycle.
    always_comb begin
        hg_elig  = '0;
        wt_elig  = '0;
        cnt_inc  = '0;
        cnt_dec  = '0;
        cnt_zero = '0;
        busy     = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_zero[w] = (outstanding[w] == '0);
            hg_elig[w]  = slot_valid[w] && !slot_wait[w] && (outstanding[w] < MAX_CNT);
            wt_elig[w]  = slot_valid[w] && slot_wait[w] && cnt_zero[w] &&
                          !(done_valid && done_wid == NW_WIDTH'(w));
            cnt_dec[w]  = done_valid && (done_wid == NW_WIDTH'(w));
            busy[w]     = slot_valid[w] || !cnt_zero[w];
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_inc[w] = ia_load && (ia_win == NW_WIDTH'(w));
        end
    end

    assign {ia_any, ia_win} = rr_pick(hg_elig, ia_ptr);
    assign {wt_any, wt_win} = rr_pick(wt_elig, wt_ptr);
    assign ia_load = (!initiate_valid || initiate_ready) && ia_any;
    assign wt_load = (!wait_valid || wait_ready) && wt_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            initiate_valid <= 1'b0;
            initiate_wid   <= '0;
            ia_ptr         <= '0;
        end else if (ia_load) begin
            initiate_valid <= 1'b1;
            initiate_wid   <= ia_win;
            ia_ptr         <= next_ptr(ia_win);
        end else if (initiate_ready) begin
            initiate_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_valid <= 1'b0;
            wait_wid   <= '0;
            wt_ptr     <= '0;
        end else if (wt_load) begin
            wait_valid <= 1'b1;
            wait_wid   <= wt_win;
            wt_ptr     <= next_ptr(wt_win);
        end else if (wait_ready) begin
            wait_valid <= 1'b0;
        end
    end

    // A slot is only written when empty and only drained when full, so set and clear never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid <= '0;
            slot_wait  <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (req_fire && req_wid == NW_WIDTH'(w)) begin
                    slot_valid[w] <= 1'b1;
                    slot_wait[w]  <= req_is_wait;
                end else if ((ia_load && ia_win == NW_WIDTH'(w)) ||
                             (wt_load && wt_win == NW_WIDTH'(w))) begin
                    slot_valid[w] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) outstanding[w] <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (cnt_inc[w] && !cnt_dec[w]) begin
                    outstanding[w] <= outstanding[w] + CNT_W'(1);
                end else if (cnt_dec[w] && !cnt_inc[w] && !cnt_zero[w]) begin
                    outstanding[w] <= outstanding[w] - CNT_W'(1);
                end
            end
            if (|(cnt_dec & cnt_zero)) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tensor_hgmma_scheduler.sv
// Self-checking bench for tensor_hgmma_scheduler: vector table, directed corner
// sequences and randomized traffic against a per-warp reference model.
module tb_tensor_hgmma_scheduler;

    localparam int NW   = 4;
    localparam int MAXO = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid, req_is_wait, initiate_ready, done_valid, wait_ready;
    logic [1:0] req_wid, done_wid;
    logic       req_ready, initiate_valid, wait_valid, err_underflow;
    logic [1:0] initiate_wid, wait_wid;
    logic [3:0] busy;

    int n_cmp = 0;
    int n_fail = 0;

    tensor_hgmma_scheduler #(.NUM_WARPS(NW), .NW_WIDTH(2), .MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_is_wait(req_is_wait),
        .initiate_valid(initiate_valid), .initiate_wid(initiate_wid), .initiate_ready(initiate_ready),
        .done_valid(done_valid), .done_wid(done_wid),
        .wait_valid(wait_valid), .wait_wid(wait_wid), .wait_ready(wait_ready),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Reference state: what each warp holds and what each output register presents.
    bit m_sv [NW];
    bit m_sw [NW];
    int m_cnt [NW];
    int m_iap, m_wtp, m_iw, m_ww;
    bit m_iv, m_wv, m_err;

    typedef struct {
        logic       rv;
        logic [1:0] wid;
        logic       isw;
        logic       ir;
        logic       dv;
        logic [1:0] dwid;
        logic       wr;
        logic       e_rr;
        logic       e_iv;
        logic [1:0] e_iw;
        logic       e_wv;
        logic [3:0] e_busy;
        logic       e_err;
    } vec_t;

    vec_t vec [15];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rv, input logic [1:0] wid, input logic isw, input logic ir,
                                  input logic dv, input logic [1:0] dwid, input logic wr);
        req_valid = rv; req_wid = wid; req_is_wait = isw; initiate_ready = ir;
        done_valid = dv; done_wid = dwid; wait_ready = wr;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_sv[w] = 0; m_sw[w] = 0; m_cnt[w] = 0;
        end
        m_iap = 0; m_wtp = 0; m_iw = 0; m_ww = 0; m_iv = 0; m_wv = 0; m_err = 0;
    endtask

    function automatic int rr_first(input int ptr, input logic [NW-1:0] el);
        for (int k = 0; k < NW; k++) begin
            if (el[(ptr + k) % NW]) return (ptr + k) % NW;
        end
        return -1;
    endfunction

    task automatic model_update();
        logic [NW-1:0] ia_el, wt_el;
        int ia_w, wt_w;
        bit fire, inc, dec;
        fire = req_valid && !m_sv[req_wid];
        for (int w = 0; w < NW; w++) begin
            ia_el[w] = m_sv[w] && !m_sw[w] && (m_cnt[w] < MAXO);
            wt_el[w] = m_sv[w] && m_sw[w] && (m_cnt[w] == 0) && !(done_valid && int'(done_wid) == w);
        end
        ia_w = (!m_iv || initiate_ready) ? rr_first(m_iap, ia_el) : -1;
        wt_w = (!m_wv || wait_ready) ? rr_first(m_wtp, wt_el) : -1;
        for (int w = 0; w < NW; w++) begin
            inc = (ia_w == w);
            dec = done_valid && int'(done_wid) == w;
            if (dec && m_cnt[w] == 0) m_err = 1;
            if (inc && !dec) m_cnt[w]++;
            else if (dec && !inc && m_cnt[w] > 0) m_cnt[w]--;
        end
        if (ia_w >= 0) begin
            m_iv = 1; m_iw = ia_w; m_iap = (ia_w + 1) % NW; m_sv[ia_w] = 0;
        end else if (initiate_ready) m_iv = 0;
        if (wt_w >= 0) begin
            m_wv = 1; m_ww = wt_w; m_wtp = (wt_w + 1) % NW; m_sv[wt_w] = 0;
        end else if (wait_ready) m_wv = 0;
        if (fire) begin
            m_sv[req_wid] = 1; m_sw[req_wid] = req_is_wait;
        end
    endtask

    task automatic model_compare();
        logic [3:0] mb;
        for (int w = 0; w < NW; w++) mb[w] = m_sv[w] || (m_cnt[w] != 0);
        check_output("model req_ready", req_ready, !m_sv[req_wid]);
        check_output("model initiate_valid", initiate_valid, m_iv);
        check_output("model initiate_wid", initiate_wid, m_iw);
        check_output("model wait_valid", wait_valid, m_wv);
        check_output("model wait_wid", wait_wid, m_ww);
        check_output("model busy", busy, mb);
        check_output("model err_underflow", err_underflow, m_err);
    endtask

    task automatic step_pre();
        #1;
        model_compare();
    endtask

    task automatic step_post();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] dw;
        logic       dv;
        //           rv wid   isw ir dv dwid  wr  rr iv iw    wv busy     err
        vec[0]  = '{1, 2'd1, 0, 1, 0, 2'd0, 1,  1, 0, 2'd0, 0, 4'b0000, 0};
        vec[1]  = '{0, 2'd1, 0, 1, 0, 2'd0, 1,  0, 0, 2'd0, 0, 4'b0010, 0};
        vec[2]  = '{0, 2'd1, 0, 1, 0, 2'd0, 1,  1, 1, 2'd1, 0, 4'b0010, 0};
        vec[3]  = '{0, 2'd1, 0, 1, 1, 2'd1, 1,  1, 0, 2'd0, 0, 4'b0010, 0};
        vec[4]  = '{1, 2'd0, 0, 1, 0, 2'd0, 1,  1, 0, 2'd0, 0, 4'b0000, 0};
        vec[5]  = '{1, 2'd2, 0, 1, 0, 2'd0, 1,  1, 0, 2'd0, 0, 4'b0001, 0};
        vec[6]  = '{1, 2'd3, 0, 1, 0, 2'd0, 1,  1, 1, 2'd0, 0, 4'b0101, 0};
        vec[7]  = '{0, 2'd3, 0, 1, 0, 2'd0, 1,  0, 1, 2'd2, 0, 4'b1101, 0};
        vec[8]  = '{0, 2'd3, 0, 1, 0, 2'd0, 1,  1, 1, 2'd3, 0, 4'b1101, 0};
        vec[9]  = '{0, 2'd3, 0, 1, 1, 2'd0, 1,  1, 0, 2'd0, 0, 4'b1101, 0};
        vec[10] = '{0, 2'd3, 0, 1, 1, 2'd2, 1,  1, 0, 2'd0, 0, 4'b1100, 0};
        vec[11] = '{0, 2'd3, 0, 1, 1, 2'd3, 1,  1, 0, 2'd0, 0, 4'b1000, 0};
        vec[12] = '{0, 2'd3, 0, 1, 1, 2'd3, 1,  1, 0, 2'd0, 0, 4'b0000, 0};
        vec[13] = '{0, 2'd3, 0, 1, 0, 2'd0, 1,  1, 0, 2'd0, 0, 4'b0000, 1};
        vec[14] = '{0, 2'd3, 0, 1, 0, 2'd0, 1,  1, 0, 2'd0, 0, 4'b0000, 1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vec[i].rv, vec[i].wid, vec[i].isw, vec[i].ir, vec[i].dv, vec[i].dwid, vec[i].wr);
            step_pre();
            check_output($sformatf("vec%0d req_ready", i), req_ready, vec[i].e_rr);
            check_output($sformatf("vec%0d initiate_valid", i), initiate_valid, vec[i].e_iv);
            if (vec[i].e_iv) check_output($sformatf("vec%0d initiate_wid", i), initiate_wid, vec[i].e_iw);
            check_output($sformatf("vec%0d wait_valid", i), wait_valid, vec[i].e_wv);
            check_output($sformatf("vec%0d busy", i), busy, vec[i].e_busy);
            check_output($sformatf("vec%0d err_underflow", i), err_underflow, vec[i].e_err);
            step_post();
        end

        // Outstanding limit: third HGMMA of warp 0 waits in its slot until a done arrives.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply_stimulus(c <= 4, 2'd0, 0, 1, c == 6, 2'd0, 1);
            step_pre();
            case (c)
                1: check_output("limit second req blocked", req_ready, 0);
                3: check_output("limit third req blocked", req_ready, 0);
                5: check_output("limit third held ready", req_ready, 0);
                6: check_output("limit held at done", initiate_valid, 0);
                7: check_output("limit held after done", initiate_valid, 0);
                8: begin
                    check_output("limit third issued", initiate_valid, 1);
                    check_output("limit third wid", initiate_wid, 0);
                end
                default: ;
            endcase
            step_post();
        end

        // Wait release two cycles after the last done, then held while commit stalls.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            apply_stimulus(c <= 2, 2'd2, c >= 1, 1, c == 4, 2'd2, c >= 11);
            step_pre();
            if (c <= 5) check_output($sformatf("wait c%0d not released", c), wait_valid, 0);
            if (c >= 6 && c <= 11) begin
                check_output($sformatf("wait c%0d held valid", c), wait_valid, 1);
                check_output($sformatf("wait c%0d held wid", c), wait_wid, 2);
            end
            if (c == 12) check_output("wait drained", wait_valid, 0);
            step_post();
        end

        // Kickoff stall with two eligible warps, then async reset while a kickoff is pending.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply_stimulus(c <= 2, (c == 1) ? 2'd1 : 2'd0, 0, c >= 6, 0, 2'd0, 1);
            step_pre();
            if (c >= 2 && c <= 6) check_output($sformatf("stall c%0d wid", c), initiate_wid, 0);
            if (c == 7) check_output("stall next grant other warp", initiate_wid, 1);
            if (c == 8) begin
                check_output("stall pre-reset valid", initiate_valid, 1);
                #2 reset = 1'b0;
                #1;
                check_output("async reset initiate_valid", initiate_valid, 0);
                check_output("async reset initiate_wid", initiate_wid, 0);
                check_output("async reset wait_valid", wait_valid, 0);
                check_output("async reset busy", busy, 0);
                check_output("async reset err", err_underflow, 0);
                model_reset();
                @(posedge clk);
                #1 reset = 1'b1;
            end else begin
                step_post();
            end
        end

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            dw = 2'($urandom_range(0, 3));
            dv = (m_cnt[dw] > 0) && ($urandom_range(0, 2) == 0);
            apply_stimulus($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                           $urandom_range(0, 9) < 7, dv, dw, $urandom_range(0, 9) < 7);
            step_pre();
            step_post();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
